// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    // Width of the data-grant streak counter; holds max_streak values up to 15.
    localparam int unsigned ARB_STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Fetch starvation guard: counts consecutive data grants made while fetch waits.
// Only compiled when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module starve_counter
    import arb_pkg::*;
#(
    parameter int unsigned max_streak = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic grant_fetch,
    input  logic grant_data,
    input  logic fetch_req,
    output logic at_limit
);

    logic [ARB_STREAK_W-1:0] streak_q;

    // Streak count: bump on a data grant that passes over a waiting fetch, clear otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q <= '0;
        end else if (grant_fetch) begin
            streak_q <= '0;
        end else if (grant_data) begin
            streak_q <= fetch_req ? streak_q + 1'b1 : '0;
        end
    end

    assign at_limit = (streak_q == ARB_STREAK_W'(max_streak));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between a fetch requester and a load/store
// requester. Data has priority; defining ARB_STARVE_GUARD_EN adds a streak
// limit that forces a fetch grant after max_streak data grants in a row.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned bus_width  = 32,
    parameter int unsigned max_streak = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [bus_width-1:0] fetch_addr,
    output logic                 fetch_valid,
    output logic [bus_width-1:0] fetch_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [bus_width-1:0] data_addr,
    input  logic [bus_width-1:0] data_wdata,
    output logic                 data_valid,
    output logic [bus_width-1:0] data_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [bus_width-1:0] mem_addr,
    output logic [bus_width-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [bus_width-1:0] mem_rdata,
    output logic                 fetch_freeze
);

    if (max_streak < 1 || max_streak > 15) begin : g_bad_max_streak
        $error("mem_port_arbiter: max_streak must be in 1..15");
    end

    arb_state_t           state_q, state_d;
    logic                 grant_fetch, grant_data;
    logic                 force_fetch;
    logic                 busy;
    logic [bus_width-1:0] cap_addr, cap_wdata;
    logic                 cap_we;

`ifdef ARB_STARVE_GUARD_EN
    starve_counter #(
        .max_streak(max_streak)
    ) u_starve_counter (
        .clock      (clock),
        .reset      (reset),
        .grant_fetch(grant_fetch),
        .grant_data (grant_data),
        .fetch_req  (fetch_req),
        .at_limit   (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration in idle, completion detection while busy.
    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_fetch = fetch_req & (~data_req | force_fetch);
                grant_data  = data_req & ~grant_fetch;
                if (grant_fetch) begin
                    state_d = ARB_FETCH;
                end else if (grant_data) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (mem_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Capture the winner's payload so requester changes cannot disturb the transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else if (grant_fetch) begin
            cap_addr  <= fetch_addr;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else if (grant_data) begin
            cap_addr  <= data_addr;
            cap_we    <= data_we;
            cap_wdata <= data_wdata;
        end
    end

    // Completion: route read data to the owner and pulse its valid for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            if (mem_ready && state_q == ARB_FETCH) begin
                fetch_valid <= 1'b1;
                fetch_rdata <= mem_rdata;
            end else if (mem_ready && state_q == ARB_DATA) begin
                data_valid <= 1'b1;
                data_rdata <= cap_we ? '0 : mem_rdata;
            end
        end
    end

    assign busy         = (state_q == ARB_FETCH) || (state_q == ARB_DATA);
    assign mem_req      = busy;
    assign mem_we       = busy & cap_we;
    assign mem_addr     = busy ? cap_addr  : '0;
    assign mem_wdata    = busy ? cap_wdata : '0;
    assign fetch_freeze = fetch_req & ~fetch_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        fetch_freeze;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .bus_width (32),
        .max_streak(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_valid  (data_valid),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .fetch_freeze(fetch_freeze)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("rst_dvalid", {31'd0, data_valid}, 32'd0);
        check("rst_frdata", fetch_rdata, 32'd0);
        check("rst_drdata", data_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_freeze", {31'd0, fetch_freeze}, 32'd0);

        // Fetch-only read, payload change mid-flight, stray mem_ready in idle
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        #1;
        check("f1_freeze_req", {31'd0, fetch_freeze}, 32'd1);
        step();
        check("f1_mem_req", {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr", mem_addr, 32'h10);
        check("f1_mem_we", {31'd0, mem_we}, 32'd0);
        check("f1_mem_wdata", mem_wdata, 32'd0);
        fetch_addr = 32'h20;
        step();
        check("f1_addr_hold", mem_addr, 32'h10);
        check("f1_no_valid_early", {31'd0, fetch_valid}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        check("f1_fvalid", {31'd0, fetch_valid}, 32'd1);
        check("f1_frdata", fetch_rdata, 32'hDEADBEEF);
        check("f1_mem_req_low", {31'd0, mem_req}, 32'd0);
        check("f1_freeze_off", {31'd0, fetch_freeze}, 32'd0);
        check("f1_dvalid", {31'd0, data_valid}, 32'd0);
        fetch_req = 1'b0;
        mem_rdata = 32'h0BADF00D;
        step();
        check("stray_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("stray_dvalid", {31'd0, data_valid}, 32'd0);
        check("stray_mem_req", {31'd0, mem_req}, 32'd0);
        check("stray_frdata_hold", fetch_rdata, 32'hDEADBEEF);
        mem_ready = 1'b0;
        step();

        // Simultaneous requests: data store first, then fetch after one idle cycle
        fetch_req  = 1'b1;
        fetch_addr = 32'h30;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h40;
        data_wdata = 32'h55;
        step();
        check("both_mem_we", {31'd0, mem_we}, 32'd1);
        check("both_mem_addr", mem_addr, 32'h40);
        check("both_mem_wdata", mem_wdata, 32'h55);
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        check("st_dvalid", {31'd0, data_valid}, 32'd1);
        check("st_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("st_drdata_zero", data_rdata, 32'd0);
        check("st_turnaround", {31'd0, mem_req}, 32'd0);
        check("st_freeze", {31'd0, fetch_freeze}, 32'd1);
        data_req  = 1'b0;
        mem_ready = 1'b0;
        step();
        check("f2_mem_req", {31'd0, mem_req}, 32'd1);
        check("f2_mem_addr", mem_addr, 32'h30);
        check("f2_mem_we", {31'd0, mem_we}, 32'd0);
        check("f2_mem_wdata", mem_wdata, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        check("f2_fvalid", {31'd0, fetch_valid}, 32'd1);
        check("f2_frdata", fetch_rdata, 32'hCAFEF00D);
        check("f2_drdata_hold", data_rdata, 32'd0);
        fetch_req = 1'b0;
        mem_ready = 1'b0;
        step();

        // Load returns memory data
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h44;
        step();
        check("ld_mem_we", {31'd0, mem_we}, 32'd0);
        check("ld_mem_addr", mem_addr, 32'h44);
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        step();
        check("ld_dvalid", {31'd0, data_valid}, 32'd1);
        check("ld_drdata", data_rdata, 32'hA5A5A5A5);
        check("ld_frdata_hold", fetch_rdata, 32'hCAFEF00D);
        data_req  = 1'b0;
        mem_ready = 1'b0;
        step();

        // Both held continuously with mem_ready always high
        fetch_req  = 1'b1;
        fetch_addr = 32'h100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h200;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h77;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] exp_addr;
`ifdef ARB_STARVE_GUARD_EN
            exp_addr = (i % 5 == 4) ? 32'h100 : 32'h200;
`else
            exp_addr = 32'h200;
`endif
            step();
            check($sformatf("streak_grant%0d", i), mem_addr, exp_addr);
            check($sformatf("streak_req%0d", i), {31'd0, mem_req}, 32'd1);
            step();
            check($sformatf("streak_onehot%0d", i), {30'd0, fetch_valid, data_valid},
                  (exp_addr == 32'h100) ? 32'd2 : 32'd1);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        mem_ready = 1'b0;
        step();
        step();

        // Reset abandons an in-flight data transaction
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h40;
        data_wdata = 32'h55;
        step();
        check("rs_busy", {31'd0, mem_req}, 32'd1);
        step();
        reset    = 1'b1;
        data_req = 1'b0;
        step();
        check("rs_mem_req", {31'd0, mem_req}, 32'd0);
        check("rs_mem_addr", mem_addr, 32'd0);
        check("rs_mem_wdata", mem_wdata, 32'd0);
        check("rs_mem_we", {31'd0, mem_we}, 32'd0);
        check("rs_frdata", fetch_rdata, 32'd0);
        check("rs_drdata", data_rdata, 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h99;
        step();
        check("rs_no_dvalid", {31'd0, data_valid}, 32'd0);
        check("rs_no_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("rs_idle", {31'd0, mem_req}, 32'd0);
        check("rs_drdata_after", data_rdata, 32'd0);
        mem_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
